// File: rtl/pcs_lane_align_ctrl.sv
// RX multi-lane alignment controller: waits for block lock, deskews lanes by
// holding early deskew FIFOs, then flywheels on the alignment-marker period.
`timescale 1ns/1ps
module pcs_lane_align_ctrl #(
  parameter int unsigned NUM_LANES        = 4,
  parameter int unsigned AM_PERIOD        = 16384,
  parameter int unsigned MAX_SKEW         = 31,
  parameter int unsigned AM_INVALID_LIMIT = 4
) (
  input  logic                 core_clk,
  input  logic                 core_reset_n,
  input  logic [NUM_LANES-1:0] block_locked,
  input  logic [NUM_LANES-1:0] marker_detect,
  input  logic [NUM_LANES-1:0] bip_valid,
  output logic [NUM_LANES-1:0] fifo_rd_en,
  output logic                 fifo_flush,
  output logic                 align_status,
  output logic                 skew_error,
  output logic [15:0]          bip_err_cnt
);

  localparam int unsigned AM_W   = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam int unsigned SKEW_W = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1;
  localparam int unsigned BAD_W  = $clog2(AM_INVALID_LIMIT + 1);
  localparam logic [AM_W-1:0]   AM_LAST   = AM_W'(AM_PERIOD - 1);
  localparam logic [SKEW_W-1:0] SKEW_LAST = SKEW_W'(MAX_SKEW);
  localparam logic [BAD_W-1:0]  BAD_LIMIT = BAD_W'(AM_INVALID_LIMIT);

  typedef enum logic [1:0] {WAIT_LOCK, FIND, ALIGNED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LANES-1:0]   seen_q, seen_d;
  logic [SKEW_W-1:0]      skew_q, skew_d;
  logic [AM_W-1:0]        am_cnt_q [NUM_LANES];
  logic [BAD_W-1:0]       bad_q    [NUM_LANES];
  logic [BAD_W-1:0]       bad_d    [NUM_LANES];
  logic [NUM_LANES-1:0]   rd_en_d;
  logic                   flush_d;
  logic                   skew_err_d;
  logic                   align_d;
  logic [15:0]            bip_d;
  logic [NUM_LANES-1:0]   hit;
  logic                   lost;
  logic [16:0]            bip_sum;

  // Marker phase tracking runs in every state so the flywheel is primed on entry to ALIGNED.
  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) am_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (marker_detect[i] || (am_cnt_q[i] == AM_LAST)) am_cnt_q[i] <= '0;
        else                                              am_cnt_q[i] <= am_cnt_q[i] + AM_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    skew_d     = skew_q;
    bad_d      = bad_q;
    rd_en_d    = '1;
    flush_d    = 1'b0;
    skew_err_d = 1'b0;
    bip_d      = bip_err_cnt;
    hit        = seen_q | marker_detect;
    lost       = 1'b0;
    bip_sum    = {1'b0, bip_err_cnt};

    case (state_q)
      WAIT_LOCK: begin
        seen_d = '0;
        skew_d = '0;
        if (&block_locked) state_d = FIND;
      end
      FIND: begin
        if (&hit) begin
          state_d = ALIGNED;
          seen_d  = '0;
          skew_d  = '0;
        end else if (skew_q == SKEW_LAST) begin
          skew_err_d = 1'b1;
          flush_d    = 1'b1;
          seen_d     = '0;
          skew_d     = '0;
        end else begin
          seen_d  = hit;
          rd_en_d = ~hit;
          skew_d  = (|hit) ? skew_q + SKEW_W'(1) : '0;
        end
      end
      ALIGNED: begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (am_cnt_q[i] == AM_LAST)
            bad_d[i] = marker_detect[i] ? '0 : bad_q[i] + BAD_W'(1);
          else if (marker_detect[i])
            bad_d[i] = bad_q[i] + BAD_W'(1);
          if (bad_d[i] >= BAD_LIMIT) lost = 1'b1;
          if (marker_detect[i] && !bip_valid[i]) bip_sum = bip_sum + 17'd1;
        end
        bip_d = bip_sum[16] ? 16'hFFFF : bip_sum[15:0];
        if (lost) begin
          state_d = FIND;
          flush_d = 1'b1;
          for (int unsigned i = 0; i < NUM_LANES; i++) bad_d[i] = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss overrides every other decision taken above.
    if ((state_q != WAIT_LOCK) && !(&block_locked)) begin
      state_d    = WAIT_LOCK;
      flush_d    = 1'b1;
      skew_err_d = 1'b0;
      rd_en_d    = '1;
      seen_d     = '0;
      skew_d     = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) bad_d[i] = '0;
    end

    align_d = (state_d == ALIGNED);
  end

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state_q      <= WAIT_LOCK;
      seen_q       <= '0;
      skew_q       <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) bad_q[i] <= '0;
      fifo_rd_en   <= '1;
      fifo_flush   <= 1'b0;
      align_status <= 1'b0;
      skew_error   <= 1'b0;
      bip_err_cnt  <= '0;
    end else begin
      state_q      <= state_d;
      seen_q       <= seen_d;
      skew_q       <= skew_d;
      bad_q        <= bad_d;
      fifo_rd_en   <= rd_en_d;
      fifo_flush   <= flush_d;
      align_status <= align_d;
      skew_error   <= skew_err_d;
      bip_err_cnt  <= bip_d;
    end
  end

endmodule

// File: tb/tb_pcs_lane_align_ctrl.sv
// Randomized self-checking bench for pcs_lane_align_ctrl against arrival-time
// and marker-schedule expectations.
`timescale 1ns/1ps
module tb_pcs_lane_align_ctrl;

  localparam int P      = 64;
  localparam int MS     = 31;
  localparam int ABSENT = 100000;

  logic        core_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  locked, md, bv;
  logic [3:0]  rd;
  logic        flush, align, skew;
  logic [15:0] bip;
  logic [3:0]  s_locked, s_md, s_bv;
  logic [3:0]  s_rd;
  logic        s_flush, s_align, s_skew;
  logic [15:0] s_bip;

  int n_vec = 0;
  int n_err = 0;

  always #5 core_clk = ~core_clk;

  pcs_lane_align_ctrl #(.NUM_LANES(4), .AM_PERIOD(P), .MAX_SKEW(MS), .AM_INVALID_LIMIT(4)) u_dut (
    .core_clk(core_clk), .core_reset_n(rst_n), .block_locked(locked),
    .marker_detect(md), .bip_valid(bv), .fifo_rd_en(rd), .fifo_flush(flush),
    .align_status(align), .skew_error(skew), .bip_err_cnt(bip));

  pcs_lane_align_ctrl #(.NUM_LANES(4), .AM_PERIOD(2), .MAX_SKEW(MS), .AM_INVALID_LIMIT(4)) u_sat (
    .core_clk(core_clk), .core_reset_n(rst_n), .block_locked(s_locked),
    .marker_detect(s_md), .bip_valid(s_bv), .fifo_rd_en(s_rd), .fifo_flush(s_flush),
    .align_status(s_align), .skew_error(s_skew), .bip_err_cnt(s_bip));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1);
  end

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  // Leaves both DUTs in FIND at the returned point (call it cycle 0).
  task automatic reset_lock();
    rst_n = 1'b0; locked = '1; md = '0; bv = '1;
    s_locked = '1; s_md = '0; s_bv = '1;
    repeat (2) @(posedge core_clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; locked = '1; md = '1; bv = '0;
    s_locked = '1; s_md = '1; s_bv = '0;
    repeat (3) @(posedge core_clk);
    #1;
    n_vec++; if (rd !== 4'hF)     begin n_err++; $display("FAIL rst_rd got %b exp 1111", rd); end
    n_vec++; if (flush !== 1'b0)  begin n_err++; $display("FAIL rst_flush got %b exp 0", flush); end
    n_vec++; if (align !== 1'b0)  begin n_err++; $display("FAIL rst_align got %b exp 0", align); end
    n_vec++; if (skew !== 1'b0)   begin n_err++; $display("FAIL rst_skew got %b exp 0", skew); end
    n_vec++; if (bip !== 16'h0)   begin n_err++; $display("FAIL rst_bip got %h exp 0000", bip); end
    n_vec++; if (s_bip !== 16'h0) begin n_err++; $display("FAIL rst_sbip got %h exp 0000", s_bip); end
    reset_lock();
    md = 4'b0001;
    step();
    md = '0;
    n_vec++; if (rd !== 4'b1110) begin n_err++; $display("FAIL rst_pre_hold got %b exp 1110", rd); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (rd !== 4'hF)    begin n_err++; $display("FAIL async_rst_rd got %b exp 1111", rd); end
    step();
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL async_rst_flush got %b exp 0", flush); end
  endtask

  // Expectations from arrival times: a lane is held from its arrival+1 until the
  // last arrival, provided the spread fits MAX_SKEW; otherwise the window expires.
  task automatic run_find(input int a0, input int a1, input int a2, input int a3);
    int arr[4];
    int first, last, endc;
    bit ok;
    logic [3:0] er;
    logic ea, es;
    arr = '{a0, a1, a2, a3};
    first = arr[0]; last = arr[0];
    for (int i = 1; i < 4; i++) begin
      if (arr[i] < first) first = arr[i];
      if (arr[i] > last)  last  = arr[i];
    end
    ok   = (last - first) <= MS;
    endc = ok ? last + 3 : first + 32;
    reset_lock();
    for (int c = 0; c <= endc; c++) begin
      for (int i = 0; i < 4; i++)
        er[i] = ok ? !(arr[i] < c && c <= last) : !(arr[i] < c && c <= first + 31);
      ea = ok && (c > last);
      es = !ok && (c == first + 32);
      n_vec++; if (rd !== er)    begin n_err++; $display("FAIL find_rd c=%0d got %b exp %b", c, rd, er); end
      n_vec++; if (align !== ea) begin n_err++; $display("FAIL find_align c=%0d got %b exp %b", c, align, ea); end
      n_vec++; if (skew !== es)  begin n_err++; $display("FAIL find_skew c=%0d got %b exp %b", c, skew, es); end
      n_vec++; if (flush !== es) begin n_err++; $display("FAIL find_flush c=%0d got %b exp %b", c, flush, es); end
      for (int i = 0; i < 4; i++) md[i] = (arr[i] == c);
      bv = 4'($urandom);
      step();
    end
    md = '0;
  endtask

  task automatic test_find_plan();
    run_find(10, 12, 15, 11);
  endtask

  task automatic test_skew_timeout();
    run_find(10, 10, 10, ABSENT);
  endtask

  task automatic test_skew_boundary();
    run_find(5, 36, 20, 5);
    run_find(5, 37, 20, 5);
  endtask

  task automatic test_find_random();
    for (int n = 0; n < 10; n++)
      run_find(2 + $urandom_range(0, 40), 2 + $urandom_range(0, 40),
               2 + $urandom_range(0, 40), 2 + $urandom_range(0, 40));
  endtask

  // All lanes see their marker at cycle a; ALIGNED from a+1.
  task automatic go_aligned(output int a);
    reset_lock();
    a = 3;
    for (int c = 0; c <= a; c++) begin
      md = (c == a) ? '1 : '0;
      bv = 4'($urandom);
      step();
    end
    md = '0;
  endtask

  task automatic test_drop_lane();
    int a, d, k;
    logic ea, ef;
    go_aligned(a);
    d = $urandom_range(0, 3);
    for (int c = a + 1; c <= a + 5 * P + 3; c++) begin
      ea = (c <= a + 4 * P) || (c >= a + 5 * P + 1);
      ef = (c == a + 4 * P + 1);
      n_vec++; if (align !== ea) begin n_err++; $display("FAIL drop_align c=%0d got %b exp %b", c, align, ea); end
      n_vec++; if (flush !== ef) begin n_err++; $display("FAIL drop_flush c=%0d got %b exp %b", c, flush, ef); end
      n_vec++; if (rd !== 4'hF)  begin n_err++; $display("FAIL drop_rd c=%0d got %b exp 1111", c, rd); end
      k = (c - a) / P;
      for (int i = 0; i < 4; i++)
        md[i] = ((c - a) % P == 0) && !(i == d && k >= 1 && k <= 4);
      step();
    end
    md = '0;
  endtask

  task automatic test_marker_recovery();
    int a, d, k;
    go_aligned(a);
    d = $urandom_range(0, 3);
    for (int c = a + 1; c <= a + 8 * P + 2; c++) begin
      n_vec++; if (align !== 1'b1) begin n_err++; $display("FAIL recov_align c=%0d got %b exp 1", c, align); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL recov_flush c=%0d got %b exp 0", c, flush); end
      k = (c - a) / P;
      for (int i = 0; i < 4; i++)
        md[i] = ((c - a) % P == 0) && !(i == d && k != 4 && k >= 1 && k <= 7);
      step();
    end
    md = '0;
  endtask

  task automatic test_stray_marker();
    int a, d;
    int s[4];
    logic ea, ef;
    go_aligned(a);
    d = $urandom_range(0, 3);
    for (int j = 0; j < 4; j++) s[j] = a + j * 12 + $urandom_range(1, 10);
    for (int c = a + 1; c <= s[3] + 2; c++) begin
      ea = (c <= s[3]);
      ef = (c == s[3] + 1);
      n_vec++; if (align !== ea) begin n_err++; $display("FAIL stray_align c=%0d got %b exp %b", c, align, ea); end
      n_vec++; if (flush !== ef) begin n_err++; $display("FAIL stray_flush c=%0d got %b exp %b", c, flush, ef); end
      md = '0;
      for (int j = 0; j < 4; j++) if (s[j] == c) md[d] = 1'b1;
      step();
    end
    md = '0;
  endtask

  task automatic test_lock_loss();
    int a, t, ln;
    logic ea, ef;
    logic [3:0] er;
    go_aligned(a);
    t  = a + $urandom_range(2, 40);
    ln = $urandom_range(0, 3);
    for (int c = a + 1; c <= t + 4; c++) begin
      ea = (c <= t);
      ef = (c == t + 1);
      er = (c >= t + 3) ? 4'b1110 : 4'b1111;
      n_vec++; if (align !== ea) begin n_err++; $display("FAIL lock_align c=%0d got %b exp %b", c, align, ea); end
      n_vec++; if (flush !== ef) begin n_err++; $display("FAIL lock_flush c=%0d got %b exp %b", c, flush, ef); end
      n_vec++; if (rd !== er)    begin n_err++; $display("FAIL lock_rd c=%0d got %b exp %b", c, rd, er); end
      locked = '1;
      if (c == t) locked[ln] = 1'b0;
      md = (c == t + 2) ? 4'b0001 : 4'b0000;
      step();
    end
    md = '0; locked = '1;
  endtask

  task automatic test_bip();
    int a, k, e;
    go_aligned(a);
    e = 0;
    for (int c = a + 1; c <= a + 6 * P + 1; c++) begin
      n_vec++; if (bip !== 16'(e))  begin n_err++; $display("FAIL bip_cnt c=%0d got %0d exp %0d", c, bip, e); end
      n_vec++; if (align !== 1'b1)  begin n_err++; $display("FAIL bip_align c=%0d got %b exp 1", c, align); end
      k  = (c - a) / P;
      md = ((c - a) % P == 0) ? '1 : '0;
      bv = ((c - a) % P == 0 && k == 1) ? 4'b0101 : 4'($urandom);
      if ((c - a) % P == 0) e = e + $countones(~bv);
      step();
    end
    md = '0;
  endtask

  task automatic test_bip_saturate();
    int e;
    reset_lock();
    e = 0;
    for (int c = 0; c <= 32776; c++) begin
      if (c >= 1 && (c % 512 == 0 || e >= 65500)) begin
        n_vec++; if (s_bip !== 16'(e)) begin n_err++; $display("FAIL sat_cnt c=%0d got %0d exp %0d", c, s_bip, e); end
        n_vec++; if (s_align !== 1'b1) begin n_err++; $display("FAIL sat_align c=%0d got %b exp 1", c, s_align); end
      end
      s_md = (c % 2 == 0) ? '1 : '0;
      s_bv = '0;
      if (c % 2 == 0 && c > 0) e = (e + 4 > 65535) ? 65535 : e + 4;
      step();
    end
    s_md = '0;
  endtask

  initial begin
    test_reset();
    test_find_plan();
    test_skew_timeout();
    test_skew_boundary();
    test_find_random();
    test_drop_lane();
    test_marker_recovery();
    test_stray_marker();
    test_lock_loss();
    test_bip();
    test_bip_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pcs_lane_align_ctrl.md
Name: pcs_lane_align_ctrl

Overview:
RX multi-lane alignment controller for the 40GbE PCS. It sits after the per-lane block_sync and alignment_extractor instances and sequences four external per-lane deskew FIFOs. It waits for block lock on all lanes, then equalises inter-lane skew by holding FIFO reads on early lanes. Once aligned, it flywheels on the alignment-marker period and drops alignment after repeated bad markers.

Parameters:
NUM_LANES, 4, number of PCS lanes.
AM_PERIOD, 16384, blocks per lane between alignment markers (one 66b block per lane per core_clk).
MAX_SKEW, 31, maximum tolerated marker-arrival spread in cycles. Deskew FIFO depth must be at least MAX_SKEW+2.
AM_INVALID_LIMIT, 4, consecutive bad markers on any lane that cause loss of alignment.

Ports:
core_clk  in  1  core clock
core_reset_n  in  1  asynchronous active-low reset
block_locked  in  NUM_LANES  per-lane block lock from block_sync
marker_detect  in  NUM_LANES  per-lane AM detected this cycle (deskew FIFO write side)
bip_valid  in  NUM_LANES  BIP check result, qualified by marker_detect
fifo_rd_en  out  NUM_LANES  per-lane deskew FIFO pop
fifo_flush  out  1  one-cycle pulse that empties all deskew FIFOs
align_status  out  1  all lanes locked and deskewed
skew_error  out  1  one-cycle pulse when the skew window expires
bip_err_cnt  out  16  saturating count of markers with bip_valid=0 while aligned

Behaviour:
- All outputs are registered.
- Reset values: state=WAIT_LOCK, fifo_rd_en=all 1, fifo_flush=0, align_status=0, skew_error=0, bip_err_cnt=0. Internal seen=0, skew_cnt=0, per-lane am_cnt=0, per-lane bad_cnt=0.
- FIFOs are written every cycle. fifo_rd_en[i]=0 holds lane i, so its FIFO depth grows by 1 per held cycle.
- Per-lane am_cnt runs in every state:
  - marker_detect[i] sampled in cycle t -> am_cnt[i]=0 at t+1.
  - Otherwise am_cnt increments, wrapping from AM_PERIOD-1 to 0.
- Global lock rule, highest priority, any state other than WAIT_LOCK: block_locked != all 1 -> next state WAIT_LOCK, fifo_flush=1 for one cycle, align_status=0, seen=0.
- WAIT_LOCK:
  - fifo_rd_en=all 1.
  - When block_locked=all 1 -> FIND.
- FIND:
  - seen[i] is set in the cycle after marker_detect[i]. Markers on lanes already seen are ignored.
  - fifo_rd_en[i] = ~seen[i].
  - skew_cnt is 0 while seen=0. It increments each cycle once any bit of seen is set.
  - If (seen | marker_detect) == all 1 in a cycle: next cycle state=ALIGNED, seen=0, fifo_rd_en=all 1, align_status=1. The last-arriving lane is never held.
  - Else if skew_cnt == MAX_SKEW: skew_error=1 and fifo_flush=1 for one cycle, seen=0, skew_cnt=0, fifo_rd_en=all 1, stay in FIND.
  - If all-seen and the timeout coincide, all-seen wins.
- ALIGNED:
  - fifo_rd_en=all 1.
  - Evaluation of lane i when am_cnt[i]==AM_PERIOD-1:
    - marker present -> good, bad_cnt[i]=0.
    - marker absent -> bad_cnt[i]+1.
  - marker_detect[i] with am_cnt[i] != AM_PERIOD-1 -> bad_cnt[i]+1, and am_cnt still reloads.
  - Any bad_cnt reaching AM_INVALID_LIMIT -> state FIND, align_status=0, fifo_flush pulse, all bad_cnt=0.
  - marker_detect[i] & ~bip_valid[i] -> bip_err_cnt+1, saturating at 16'hFFFF. The count is cleared only by reset. Multiple lanes in the same cycle add the number of failing lanes, still saturating.
- bad_cnt is cleared on every exit from ALIGNED.
- Asynchronous reset mid-operation returns to the reset values immediately. fifo_flush is not pulsed by reset.

Test Plan:
1. Reset, block_locked=4'hF, markers on lanes 0..3 at cycles 10,12,15,11 -> fifo_rd_en holds lanes 0,3,1 (3 lowest-to-last arrivals) for 5,4,3 cycles respectively. align_status=1 at cycle 16. Lane 2 is never held. No skew_error.
2. Markers on lanes 0,1,2 at cycle 10, lane 3 absent (MAX_SKEW=31) -> skew_error and fifo_flush pulse at cycle 42. fifo_rd_en=4'hF at cycle 42. State stays FIND.
3. Aligned with AM_PERIOD=64; drop lane 2 markers for 4 periods -> align_status falls the cycle after the 4th missed evaluation, with a fifo_flush pulse. Reacquisition succeeds when markers resume.
4. Aligned, 3 missed markers on lane 1 then one good marker, then 3 more missed -> align_status stays 1.
5. Aligned, deassert block_locked[3] for one cycle -> fifo_flush pulse, align_status=0, state WAIT_LOCK. FIND is re-entered when lock returns.
6. Aligned, marker_detect=4'hF with bip_valid=4'b0101 at a period boundary -> bip_err_cnt +2. Preload near saturation -> holds 16'hFFFF.
